mips_alu_arbiter: RTL
=====================

Name: mips_alu_arbiter

Overview:
- Shares one combinational `mips_alu` instance between two requesters, e.g. the pipeline issue port and a debug/test port.
- Arbitrates round-robin and pre-decodes the instruction for legality.
- Registers operands onto the ALU inputs and holds them for a fixed settle time.
- Captures result and flags, then returns them to the winning requester over a valid/ready response channel.

Parameters:
- ALU_LAT, 2, cycles ALU inputs are held stable before result/flag capture; legal range 1..15.
- CNT_W, 16, width of the wrapping issued-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_ins / req1_ins  in  32  MIPS instruction word.
- req0_rega / req1_rega  in  32  operand A.
- req0_regb / req1_regb  in  32  operand B.
- rsp0_valid / rsp1_valid  out  1  response held until accepted.
- rsp0_ready / rsp1_ready  in  1  response consumer ready.
- rsp_result  out  32  captured ALU result, shared by both response channels.
- rsp_flag  out  3  captured flags: [2] zero/branch-taken, [1] less-than, [0] overflow.
- rsp_err  out  1  instruction rejected as unsupported.
- alu_ins / alu_rega / alu_regb  out  32  registered ALU inputs.
- alu_result  in  32  ALU result.
- alu_flag  in  3  ALU flags.
- busy  out  1  state != IDLE.
- issued_cnt  out  CNT_W  count of legal operations completed; wraps.

Behaviour:
- States and transitions:
  - IDLE → ISSUE on accept of a legal instruction.
  - IDLE → RESP on accept of an illegal instruction.
  - ISSUE → RESP when lat_cnt == ALU_LAT-1.
  - RESP → IDLE on rspN_valid & rspN_ready of the owning requester.
- Reset values: all outputs 0; state IDLE; owner 0; lat_cnt 0; last_grant = 1, so req0 wins the first tie.
- Ready generation, IDLE only and combinational:
  - grant = the valid requester, if only one is valid.
  - If both are valid, grant = !last_grant.
  - reqN_ready = grant==N.
  - Both ready signals are 0 outside IDLE.
- On accept:
  - Latch ins/rega/regb into alu_* registers.
  - Set owner = N and last_grant = N.
  - Evaluate legality via sub-module.
- Legal set:
  - opcode 0 with funct ∈ {0,2,3,4,6,7,32..39,42,43}.
  - opcode ∈ {4,5,8..14,35,43}.
  - Everything else is illegal.
- ISSUE:
  - alu_* held constant.
  - lat_cnt increments each cycle from 0.
  - On the last cycle, register alu_result → rsp_result and alu_flag → rsp_flag; rsp_err=0; issued_cnt+1 (wraps at 2^CNT_W).
  - For opcode 4/5, rsp_result is forced to 0; the ALU drives X.
- Illegal path: rsp_result=0, rsp_flag=000, rsp_err=1; issued_cnt unchanged; alu_* still latched but ignored.
- Latency:
  - Legal: rspN_valid is high ALU_LAT+1 cycles after the accepting edge.
  - Illegal: 1 cycle after the accepting edge.
- RESP:
  - Only rsp[owner]_valid=1.
  - rsp_result/flag/err stable until handshake.
  - Backpressure may stall indefinitely.
  - No new request is accepted during RESP, including in the handshake cycle; the next accept is earliest in the following IDLE cycle.
- Boundary conditions:
  - Requester dropping valid before accept: no effect; not latched.
  - rsp_ready of the non-owner: ignored.
  - rst asserted in any state: the in-flight op is discarded, no response is issued, and all state and outputs return to reset values on that edge.
  - ALU_LAT=1: ISSUE lasts exactly one cycle.

Decomposition:
- Package mips_alu_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_ADDI.., FN_ADD..).
  - Flag bit indices FLAG_ZERO=2, FLAG_NEG=1, FLAG_OVF=0.
  - State encoding IDLE/ISSUE/RESP.
- Sub-module mips_alu_legal: combinational, input ins[31:0], output legal and is_branch.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- req0 ADD ins=0x00011020, rega=0x7FFFFFFF, regb=0x00000001, ALU attached, ALU_LAT=2 → rsp0_valid 3 cycles after accept; rsp_result=0x80000000, flag=001, err=0; issued_cnt=1.
- req0 and req1 valid same cycle after reset, both SUBU 5-3 (ins=0x00011023, rega=5, regb=3) → req0 granted first and gets result 2, flag 000; then req1 granted and gets result 2; grant alternates on repeated ties.
- req1 ins=0xFC000000 (opcode 63) → rsp1_valid 1 cycle after accept; result 0, flag 000, err=1; issued_cnt unchanged.
- BEQ ins=0x10010000, rega=regb=0x1234 → rsp_result=0, flag=100; with regb=0x1235 → flag=000.
- Hold rsp0_ready=0 for 10 cycles while req1_valid=1 → rsp0 data stable; req1_ready stays 0 throughout; req1 accepted in the cycle after the rsp0 handshake.
- Assert rst during ISSUE → next cycle busy=0, rsp*_valid=0, alu_ins=0; no response ever emitted for the discarded op.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - opcode/funct codes, flag indices and FSM states for the ALU arbiter
package mips_alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_SLLV  = 6'd4;
    localparam logic [5:0] FN_SRLV  = 6'd6;
    localparam logic [5:0] FN_SRAV  = 6'd7;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 0;

endpackage

// File: rtl/mips_alu_arbiter_if.sv
// rtl/mips_alu_arbiter_if.sv - request/response channels and ALU-side signals of the arbiter
interface mips_alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_ins, req1_ins;
    logic [31:0]      req0_rega, req1_rega;
    logic [31:0]      req0_regb, req1_regb;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [31:0]      rsp_result;
    logic [2:0]       rsp_flag;
    logic             rsp_err;
    logic [31:0]      alu_ins, alu_rega, alu_regb;
    logic [31:0]      alu_result;
    logic [2:0]       alu_flag;
    logic             busy;
    logic [CNT_W-1:0] issued_cnt;

    modport slave (
        input  req0_valid, req1_valid, req0_ins, req1_ins,
               req0_rega, req1_rega, req0_regb, req1_regb,
               rsp0_ready, rsp1_ready, alu_result, alu_flag,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp_result, rsp_flag, rsp_err,
               alu_ins, alu_rega, alu_regb, busy, issued_cnt
    );

    modport master (
        output req0_valid, req1_valid, req0_ins, req1_ins,
               req0_rega, req1_rega, req0_regb, req1_regb,
               rsp0_ready, rsp1_ready, alu_result, alu_flag,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp_result, rsp_flag, rsp_err,
               alu_ins, alu_rega, alu_regb, busy, issued_cnt
    );
endinterface

// File: rtl/mips_alu_legal.sv
// rtl/mips_alu_legal.sv - combinational legality and branch pre-decode of a MIPS instruction
module mips_alu_legal
    import mips_alu_pkg::*;
(
    input  logic [31:0] ins,
    output logic        legal,
    output logic        is_branch
);
    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_ins;

    assign op         = ins[31:26];
    assign fn         = ins[5:0];
    assign unused_ins = ^ins[25:6];

    always_comb begin
        legal     = 1'b0;
        is_branch = 1'b0;
        case (op)
            OP_RTYPE: legal = fn inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                                         [FN_ADD:FN_NOR], FN_SLT, FN_SLTU};
            OP_BEQ, OP_BNE: begin
                legal     = 1'b1;
                is_branch = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW:
                legal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_alu_arbiter.sv
// rtl/mips_alu_arbiter.sv - round-robin sharing of one external ALU between two requesters
module mips_alu_arbiter
    import mips_alu_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    mips_alu_arbiter_if.slave  bus
);
    state_t           state, state_nxt;
    logic             owner, last_grant, grant, any_valid, accept;
    logic             legal, is_branch, br_q, lat_done, rsp_hs;
    logic [3:0]       lat_cnt;
    logic [31:0]      sel_ins, sel_rega, sel_regb;
    logic [31:0]      ins_q, rega_q, regb_q, result_q;
    logic [2:0]       flag_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_grant;
        else
            grant = bus.req1_valid;
    end

    assign accept   = (state == IDLE) && any_valid;
    assign sel_ins  = grant ? bus.req1_ins  : bus.req0_ins;
    assign sel_rega = grant ? bus.req1_rega : bus.req0_rega;
    assign sel_regb = grant ? bus.req1_regb : bus.req0_regb;
    assign lat_done = (lat_cnt == 4'(ALU_LAT - 1));
    assign rsp_hs   = owner ? bus.rsp1_ready : bus.rsp0_ready;

    mips_alu_legal u_legal (
        .ins       (sel_ins),
        .legal     (legal),
        .is_branch (is_branch)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = legal ? ISSUE : RESP;
            ISSUE:   if (lat_done) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
        bus.rsp0_valid = (state == RESP) && !owner;
        bus.rsp1_valid = (state == RESP) && owner;
        bus.busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_cnt    <= 4'd0;
            br_q       <= 1'b0;
            ins_q      <= 32'd0;
            rega_q     <= 32'd0;
            regb_q     <= 32'd0;
            result_q   <= 32'd0;
            flag_q     <= 3'd0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    lat_cnt <= 4'd0;
                    if (accept) begin
                        ins_q      <= sel_ins;
                        rega_q     <= sel_rega;
                        regb_q     <= sel_regb;
                        owner      <= grant;
                        last_grant <= grant;
                        br_q       <= is_branch;
                        if (!legal) begin
                            result_q <= 32'd0;
                            flag_q   <= 3'd0;
                            err_q    <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    if (lat_done) begin
                        // Branch results from the ALU are undefined, so report zero.
                        result_q <= br_q ? 32'd0 : bus.alu_result;
                        flag_q   <= bus.alu_flag;
                        err_q    <= 1'b0;
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_ins    = ins_q;
    assign bus.alu_rega   = rega_q;
    assign bus.alu_regb   = regb_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flag   = flag_q;
    assign bus.rsp_err    = err_q;
    assign bus.issued_cnt = cnt_q;
endmodule
